// File: rtl/kf8237_page_address_latch.sv
// Rebuilds the 20-bit 8237 DMA physical address (page : high latch : low address)
// and holds the CPU-visible page registers and the port-0x80 POST code.

module kf8237_page_lane #(
  parameter int PAGE_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [PAGE_WIDTH-1:0] write_data,
  output logic [PAGE_WIDTH-1:0] page
);
  always_ff @(posedge clock or posedge reset)
    if (reset)             page <= '0;
    else if (write_enable) page <= write_data;
endmodule

module kf8237_page_address_latch #(
  parameter int PAGE_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    chip_select_n,
  input  logic [3:0]              address_in,
  input  logic                    io_write_n,
  input  logic                    io_read_n,
  input  logic [7:0]              data_bus_in,
  output logic [7:0]              data_bus_out,
  output logic                    read_enable,
  input  logic [7:0]              dma_data_bus_in,
  input  logic [7:0]              dma_address_low,
  input  logic                    address_strobe,
  input  logic                    address_enable,
  input  logic [3:0]              dma_acknowledge,
  output logic [PAGE_WIDTH+15:0]  dma_address,
  output logic                    dma_address_valid,
  output logic                    channel_error,
  output logic [7:0]              post_code
);
  localparam int NUM_CH = 4;

  typedef struct packed {
    logic       wr_n;
    logic       cs_n;
    logic [3:0] addr;
    logic [7:0] data;
  } cpu_smp_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Channel -> I/O offset, following the scrambled PC/XT page port layout.
  function automatic logic [3:0] ch_offset(input int ch);
    case (ch)
      0:       return 4'h7;
      1:       return 4'h3;
      2:       return 4'h1;
      default: return 4'h2;
    endcase
  endfunction

  cpu_smp_t                            smp_pipe [1:0];
  logic                                commit;
  logic [NUM_CH-1:0][PAGE_WIDTH-1:0]   page;
  logic [7:0]                          hi_latch;
  logic [PAGE_WIDTH-1:0]               held_page;
  logic [1:0]                          dack_ch;
  logic                                dack_ok;
  state_t                              state;

  // smp_pipe[0] is the newest sample, smp_pipe[1] the one before it.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      smp_pipe[0] <= '{wr_n: 1'b1, cs_n: 1'b1, addr: 4'h0, data: 8'h00};
      smp_pipe[1] <= '{wr_n: 1'b1, cs_n: 1'b1, addr: 4'h0, data: 8'h00};
    end else begin
      smp_pipe[0] <= '{wr_n: io_write_n, cs_n: chip_select_n, addr: address_in, data: data_bus_in};
      smp_pipe[1] <= smp_pipe[0];
    end

  assign commit = ~smp_pipe[1].wr_n & smp_pipe[0].wr_n & ~smp_pipe[1].cs_n;

  always_ff @(posedge clock or posedge reset)
    if (reset)                                       post_code <= 8'h00;
    else if (commit && smp_pipe[1].addr == 4'h0)     post_code <= smp_pipe[1].data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    localparam logic [3:0] OFF = ch_offset(g);
    kf8237_page_lane #(.PAGE_WIDTH(PAGE_WIDTH)) u_lane (
      .clock        (clock),
      .reset        (reset),
      .write_enable (commit && smp_pipe[1].addr == OFF),
      .write_data   (smp_pipe[1].data[PAGE_WIDTH-1:0]),
      .page         (page[g])
    );
  end

  assign read_enable = ~chip_select_n & ~io_read_n;

  always_comb begin
    data_bus_out = 8'h00;
    if (read_enable)
      case (address_in)
        4'h0:    data_bus_out = post_code;
        4'h1:    data_bus_out = 8'(page[2]);
        4'h2:    data_bus_out = 8'(page[3]);
        4'h3:    data_bus_out = 8'(page[1]);
        4'h7:    data_bus_out = 8'(page[0]);
        default: data_bus_out = 8'h00;
      endcase
  end

  // Transparent-latch equivalent: follows the DMA data bus while strobed.
  always_ff @(posedge clock or posedge reset)
    if (reset)               hi_latch <= 8'h00;
    else if (address_strobe) hi_latch <= dma_data_bus_in;

  always_comb begin
    dack_ch = 2'd0;
    dack_ok = 1'b1;
    case (dma_acknowledge)
      4'b0001: dack_ch = 2'd0;
      4'b0010: dack_ch = 2'd1;
      4'b0100: dack_ch = 2'd2;
      4'b1000: dack_ch = 2'd3;
      default: dack_ok = 1'b0;
    endcase
  end

  // Page is sampled once at ownership start; later register writes wait for the next period.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state         <= IDLE;
      held_page     <= '0;
      channel_error <= 1'b0;
    end else begin
      channel_error <= 1'b0;
      case (state)
        IDLE:
          if (address_enable) begin
            state         <= ACTIVE;
            held_page     <= page[dack_ch];
            channel_error <= ~dack_ok;
          end
        ACTIVE:
          if (!address_enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end

  assign dma_address_valid = (state == ACTIVE);
  assign dma_address       = dma_address_valid ? {held_page, hi_latch, dma_address_low} : '0;

endmodule

// File: tb/tb_kf8237_page_address_latch.sv
// Directed bench for kf8237_page_address_latch: CPU page/POST path and DMA address rebuild.

module tb_kf8237_page_address_latch;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        chip_select_n = 1'b1;
  logic [3:0]  address_in = 4'h0;
  logic        io_write_n = 1'b1;
  logic        io_read_n = 1'b1;
  logic [7:0]  data_bus_in = 8'h00;
  logic [7:0]  data_bus_out;
  logic        read_enable;
  logic [7:0]  dma_data_bus_in = 8'h00;
  logic [7:0]  dma_address_low = 8'h00;
  logic        address_strobe = 1'b0;
  logic        address_enable = 1'b0;
  logic [3:0]  dma_acknowledge = 4'b0000;
  logic [19:0] dma_address;
  logic        dma_address_valid;
  logic        channel_error;
  logic [7:0]  post_code;

  int n_vec = 0;
  int n_bad = 0;

  kf8237_page_address_latch #(.PAGE_WIDTH(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .chip_select_n     (chip_select_n),
    .address_in        (address_in),
    .io_write_n        (io_write_n),
    .io_read_n         (io_read_n),
    .data_bus_in       (data_bus_in),
    .data_bus_out      (data_bus_out),
    .read_enable       (read_enable),
    .dma_data_bus_in   (dma_data_bus_in),
    .dma_address_low   (dma_address_low),
    .address_strobe    (address_strobe),
    .address_enable    (address_enable),
    .dma_acknowledge   (dma_acknowledge),
    .dma_address       (dma_address),
    .dma_address_valid (dma_address_valid),
    .channel_error     (channel_error),
    .post_code         (post_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] off, input logic [7:0] d, input logic cs_n);
    chip_select_n = cs_n;
    address_in    = off;
    data_bus_in   = d;
    io_write_n    = 1'b0;
    repeat (3) tick();
    io_write_n = 1'b1;
    tick();
    tick();
    chip_select_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [3:0] off, input logic [7:0] exp);
    chip_select_n = 1'b0;
    io_read_n     = 1'b0;
    address_in    = off;
    #1;
    chk({tag, "_re"}, 32'(read_enable), 32'h1);
    chk(tag, 32'(data_bus_out), 32'(exp));
    io_read_n     = 1'b1;
    chip_select_n = 1'b1;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_addr",  32'(dma_address), 32'h0);
    chk("rst_valid", 32'(dma_address_valid), 32'h0);
    chk("rst_cherr", 32'(channel_error), 32'h0);
    chk("rst_re",    32'(read_enable), 32'h0);
    chk("rst_dbo",   32'(data_bus_out), 32'h0);
    chk("rst_post",  32'(post_code), 32'h0);
    #4 reset = 1'b0;
    tick();

    // Page / POST write and readback
    cpu_write(4'h1, 8'h5A, 1'b0);
    cpu_write(4'h7, 8'hF3, 1'b0);
    cpu_write(4'h0, 8'h42, 1'b0);
    cpu_write(4'h5, 8'hFF, 1'b0);
    rd("rd_ch2", 4'h1, 8'h0A);
    rd("rd_ch0", 4'h7, 8'h03);
    rd("rd_post", 4'h0, 8'h42);
    chk("post_code", 32'(post_code), 32'h42);
    rd("rd_off5", 4'h5, 8'h00);
    rd("rd_ch3", 4'h2, 8'h00);

    // Channel 2 transfer
    dma_data_bus_in = 8'h12; address_strobe = 1'b1; tick();
    dma_data_bus_in = 8'h99; address_strobe = 1'b0; tick();
    dma_acknowledge = 4'b0100; dma_address_low = 8'h34; address_enable = 1'b1; tick();
    chk("ch2_addr",  32'(dma_address), 32'hA1234);
    chk("ch2_valid", 32'(dma_address_valid), 32'h1);
    chk("ch2_cherr", 32'(channel_error), 32'h0);
    address_enable = 1'b0; tick();
    chk("ch2_end_valid", 32'(dma_address_valid), 32'h0);
    chk("ch2_end_addr",  32'(dma_address), 32'h0);

    // Page write mid-transfer must not disturb the held page
    cpu_write(4'h3, 8'h03, 1'b0);
    dma_acknowledge = 4'b0010; address_enable = 1'b1; tick();
    chk("ch1_addr", 32'(dma_address), 32'h31234);
    cpu_write(4'h3, 8'h09, 1'b0);
    chk("ch1_mid_addr", 32'(dma_address), 32'h31234);
    rd("ch1_mid_rd", 4'h3, 8'h09);
    dma_acknowledge = 4'b0100; tick();
    chk("ch1_dack_chg", 32'(dma_address), 32'h31234);
    address_enable = 1'b0; tick();
    dma_acknowledge = 4'b0010; address_enable = 1'b1; tick();
    chk("ch1_next_addr", 32'(dma_address), 32'h91234);
    address_enable = 1'b0; tick();

    // Non-one-hot DACK falls back to channel 0
    cpu_write(4'h7, 8'h07, 1'b0);
    dma_acknowledge = 4'b0110; address_enable = 1'b1; tick();
    chk("bad_cherr1", 32'(channel_error), 32'h1);
    chk("bad_addr",   32'(dma_address), 32'h71234);
    tick();
    chk("bad_cherr2", 32'(channel_error), 32'h0);
    chk("bad_addr2",  32'(dma_address), 32'h71234);
    address_enable = 1'b0; tick();
    chk("bad_end_cherr", 32'(channel_error), 32'h0);

    // Commit timing relative to the sampled strobe edge
    chip_select_n = 1'b0; address_in = 4'h3; data_bus_in = 8'h05; io_write_n = 1'b0;
    repeat (3) tick();
    io_write_n = 1'b1; io_read_n = 1'b0;
    tick();
    chk("wt_edge",   32'(data_bus_out), 32'h09);
    tick();
    chk("wt_commit", 32'(data_bus_out), 32'h05);
    io_read_n = 1'b1; chip_select_n = 1'b1;
    cpu_write(4'h3, 8'h0C, 1'b1);
    rd("wt_nocs", 4'h3, 8'h05);
    io_read_n = 1'b0; #1;
    chk("rd_nocs_re",  32'(read_enable), 32'h0);
    chk("rd_nocs_dbo", 32'(data_bus_out), 32'h0);
    io_read_n = 1'b1;

    // Async reset during an active period
    dma_acknowledge = 4'b0100; address_enable = 1'b1; tick();
    chk("pre_rst_addr", 32'(dma_address), 32'hA1234);
    #2 reset = 1'b1;
    #1;
    chk("arst_addr",  32'(dma_address), 32'h0);
    chk("arst_valid", 32'(dma_address_valid), 32'h0);
    address_enable = 1'b0;
    #1 reset = 1'b0;
    tick();
    rd("arst_post", 4'h0, 8'h00);
    rd("arst_ch2",  4'h1, 8'h00);
    rd("arst_ch3",  4'h2, 8'h00);
    rd("arst_ch1",  4'h3, 8'h00);
    rd("arst_ch0",  4'h7, 8'h00);
    chk("arst_post_code", 32'(post_code), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/kf8237_page_address_latch.md
Name: kf8237_page_address_latch

Overview:
- Downstream stage of the 8237 DMA controller in the KFPC-XT core.
- Rebuilds the 20-bit physical DMA address from three sources:
  - low address A7:A0 driven by the DMA controller;
  - high address A15:A8, multiplexed onto the DMA data bus and qualified by the address strobe;
  - per-channel 4-bit page registers (A19:A16) written by the CPU at I/O 0x80-0x8F.
- Also holds the port-0x80 POST code register.
- Tracks each DMA bus ownership period so the page in use is frozen for the whole transfer.

Parameters:
- PAGE_WIDTH, 4, width of each page register and of the address extension (A19:A16).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- chip_select_n  input  1  low when the CPU addresses I/O 0x80-0x8F
- address_in  input  4  CPU I/O address A3:A0
- io_write_n  input  1  CPU I/O write strobe, active low
- io_read_n  input  1  CPU I/O read strobe, active low
- data_bus_in  input  8  CPU write data
- data_bus_out  output  8  readback data
- read_enable  output  1  high while a readback is being driven
- dma_data_bus_in  input  8  DMA controller data bus output (carries A15:A8 during strobe)
- dma_address_low  input  8  DMA controller address A7:A0
- address_strobe  input  1  DMA high-address strobe
- address_enable  input  1  DMA controller owns the address bus
- dma_acknowledge  input  4  one-hot DACK3:DACK0
- dma_address  output  20  physical DMA address
- dma_address_valid  output  1  high while an ownership period is active
- channel_error  output  1  one-cycle pulse: DACK not one-hot at ownership start
- post_code  output  8  last value written to port 0x80

Behaviour:

Reset (asynchronous, active-high):
- All page registers, post_code, the high latch, the held page and held channel clear to 0.
- FSM goes to IDLE.
- Outputs: dma_address = 0x00000, dma_address_valid = 0, channel_error = 0, read_enable = 0, data_bus_out = 0x00.

CPU write path:
- io_write_n, chip_select_n, address_in and data_bus_in are registered each clock into a sample stage.
- A write commits in the cycle where the sampled io_write_n goes 0->1 (rising edge of the strobe) and the sample taken while io_write_n was low had chip_select_n = 0.
- Committed data and offset are taken from that last low sample.
- Commit latency: one clock after the strobe edge is sampled.
- Offset map:
  - 0x0 -> post_code (8 bits)
  - 0x1 -> page ch2
  - 0x2 -> page ch3
  - 0x3 -> page ch1
  - 0x7 -> page ch0
- Page writes keep data bits [3:0]; upper bits are ignored.
- All other offsets: write is ignored, with no side effects.

CPU read path (combinational):
- read_enable = ~chip_select_n & ~io_read_n.
- When read_enable is high, data_bus_out is:
  - post_code at offset 0x0;
  - {4'h0, page} for offsets 0x1/0x2/0x3/0x7;
  - 0x00 for all other offsets.
- When read_enable is low, data_bus_out = 0x00.

High address latch (74LS373 equivalent):
- While address_strobe = 1, the latch loads dma_data_bus_in every clock.
- While address_strobe = 0, it holds.
- The value captured in the last cycle the strobe was high persists until the next strobe.

Ownership FSM:
- IDLE -> ACTIVE on the first clock with address_enable = 1.
- On that transition:
  - capture the channel from dma_acknowledge;
  - copy that channel's page register into the held page.
- If dma_acknowledge is not exactly one-hot at entry:
  - pulse channel_error high for one clock;
  - use channel 0.
- ACTIVE -> IDLE on the first clock with address_enable = 0.
- ACTIVE with address_enable = 1 stays ACTIVE; a DACK change mid-period does not re-capture the channel.
- A page register write during ACTIVE updates the register but not the held page; the new value takes effect at the next IDLE->ACTIVE transition.
- A write coinciding with the IDLE->ACTIVE cycle: the held page takes the pre-write value.

Address output:
- dma_address_valid = (state == ACTIVE).
- While ACTIVE: dma_address = {held page, high latch, dma_address_low}.
- In IDLE: dma_address = 0x00000.
- No wrap or carry between fields. Page arithmetic is not performed; the 64 KiB boundary wrap is intrinsic.

Reset during ACTIVE:
- Immediate return to IDLE; all outputs go to their reset values.

Test Plan:
- Page write/read: write 0x5A to offset 0x1, 0xF3 to 0x7, 0x42 to 0x0 -> reads return 0x0A, 0x03, 0x42; post_code = 0x42; offset 0x5 reads 0x00.
- DMA ch2 transfer: page ch2 = 0xA; strobe high with dma_data_bus_in = 0x12, then low; address_enable = 1, DACK = 0100, dma_address_low = 0x34 -> dma_address = 0xA1234, valid = 1; address_enable = 0 -> valid = 0, address = 0x00000.
- Mid-transfer page write: ch1 ACTIVE with page 0x3; write 0x9 to offset 0x3 -> address keeps page 0x3. Next period -> page 0x9.
- Bad DACK: address_enable rises with DACK = 0110 and page ch0 = 0x7 -> channel_error high exactly one clock; address page = 0x7.
- Write timing: io_write_n held low 3 clocks, chip_select_n low -> page changes exactly one clock after the sampled 0->1 edge. Same write with chip_select_n high -> no change.
- Async reset while ACTIVE with address 0xA1234 -> dma_address = 0, valid = 0 immediately; all pages and post_code read 0x00.
